// File: rtl/fwd_scoreboard.sv
// ---------------------------------------------------------------------------
// fwd_scoreboard
//   Operand-forwarding network merged with a per-register countdown
//   scoreboard, placed at the decode/execute boundary.
//
//   Forwarding: every read port scans the in-flight stages youngest-first
//   (stage 0 = EX/MA ... stage N_STG-1 = MO/WB). The first stage writing the
//   requested register supplies the operand; otherwise the RF value passes.
//   Scoreboard: an accepted instruction with non-zero latency loads a
//   countdown for its target. A register stays busy while its counter is
//   non-zero. Decode is stalled on a not-yet-computed forwarded result, on a
//   busy source not covered by a valid forward, or on a busy target (WAW).
//
//   Optional build macro: FWD_SCOREBOARD_STATS_EN adds saturating 16-bit
//   counters of stall cycles and valid-forward cycles.
//
// Ports
//   iw_clk, iw_rst      clock, asynchronous active-high reset
//   iw_rd_en            per-port operand request
//   iw_rd_addr          per-port register index  [k*REG_W +: REG_W]
//   iw_rf_data          per-port register-file data [k*DATA_W +: DATA_W]
//   iw_stg_we/tgt/vld/res  per-stage write enable, target, result-ready, result
//   iw_issue, iw_issue_we, iw_issue_tgt, iw_issue_lat  decode instruction
//   iw_flush            squash the decode instruction
//   or_rd_val           forwarded operand per port
//   or_stall            hold decode this cycle (combinational)
//   or_busy             registered busy mask, one bit per register
//   or_stall_cnt, or_fwd_cnt  (stats build only)
// ---------------------------------------------------------------------------
module fwd_scoreboard #(
  parameter int DATA_W = 24,
  parameter int REG_W  = 4,
  parameter int N_RD   = 2,
  parameter int N_STG  = 3,
  parameter int LAT_W  = 3
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst,
  input  logic [N_RD-1:0]         iw_rd_en,
  input  logic [N_RD*REG_W-1:0]   iw_rd_addr,
  input  logic [N_RD*DATA_W-1:0]  iw_rf_data,
  input  logic [N_STG-1:0]        iw_stg_we,
  input  logic [N_STG*REG_W-1:0]  iw_stg_tgt,
  input  logic [N_STG-1:0]        iw_stg_vld,
  input  logic [N_STG*DATA_W-1:0] iw_stg_res,
  input  logic                    iw_issue,
  input  logic                    iw_issue_we,
  input  logic [REG_W-1:0]        iw_issue_tgt,
  input  logic [LAT_W-1:0]        iw_issue_lat,
  input  logic                    iw_flush,
  output logic [N_RD*DATA_W-1:0]  or_rd_val,
  output logic                    or_stall,
  output logic [(2**REG_W)-1:0]   or_busy
`ifdef FWD_SCOREBOARD_STATS_EN
  ,
  output logic [15:0]             or_stall_cnt,
  output logic [15:0]             or_fwd_cnt
`endif
);

  localparam int NREG = 2**REG_W;

  logic [LAT_W-1:0] r_cnt [NREG];

  logic [N_RD-1:0]  w_hit;
  logic [N_RD-1:0]  w_hit_vld;
  logic [N_RD-1:0]  w_data_haz;
  logic [N_RD-1:0]  w_sb_haz;
  logic             w_waw;
  logic             w_accept;
  logic             w_load;
  logic             w_fwd_evt;

  // Forwarding scan: the hit flag blocks older stages once a younger one
  // matched, so an older valid result never masks a younger pending one.
  always_comb begin
    or_rd_val  = iw_rf_data;
    w_hit      = '0;
    w_hit_vld  = '0;
    w_data_haz = '0;
    w_sb_haz   = '0;
    for (int k = 0; k < N_RD; k++) begin
      for (int s = 0; s < N_STG; s++) begin
        if (!w_hit[k] && iw_stg_we[s] &&
            (iw_stg_tgt[s*REG_W +: REG_W] == iw_rd_addr[k*REG_W +: REG_W])) begin
          w_hit[k]                      = 1'b1;
          w_hit_vld[k]                  = iw_stg_vld[s];
          or_rd_val[k*DATA_W +: DATA_W] = iw_stg_res[s*DATA_W +: DATA_W];
        end
      end
      w_data_haz[k] = iw_rd_en[k] && w_hit[k] && !w_hit_vld[k];
      // A valid in-flight result covers a register still counting down.
      w_sb_haz[k]   = iw_rd_en[k] && (r_cnt[iw_rd_addr[k*REG_W +: REG_W]] != '0) &&
                      !(w_hit[k] && w_hit_vld[k]);
    end
  end

  assign w_waw     = iw_issue_we && (r_cnt[iw_issue_tgt] != '0);
  assign or_stall  = iw_issue && !iw_flush && ((|w_data_haz) || (|w_sb_haz) || w_waw);
  assign w_accept  = iw_issue && !iw_flush && !or_stall;
  assign w_load    = w_accept && iw_issue_we && (iw_issue_lat != '0);
  assign w_fwd_evt = |(iw_rd_en & w_hit & w_hit_vld);

  // Countdown per register; a load never meets a running counter because
  // such an issue is stalled as WAW.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (w_load && (REG_W'(r) == iw_issue_tgt))
          r_cnt[r] <= iw_issue_lat;
        else if (r_cnt[r] != '0)
          r_cnt[r] <= r_cnt[r] - LAT_W'(1);
      end
    end
  end

  always_comb begin
    or_busy = '0;
    for (int r = 0; r < NREG; r++) or_busy[r] = (r_cnt[r] != '0);
  end

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [15:0] r_stall_cnt;
  logic [15:0] r_fwd_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    if (en && (v != 16'hFFFF)) return v + 16'd1;
    return v;
  endfunction

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      r_stall_cnt <= sat_inc(r_stall_cnt, or_stall);
      r_fwd_cnt   <= sat_inc(r_fwd_cnt, w_fwd_evt);
    end
  end

  assign or_stall_cnt = r_stall_cnt;
  assign or_fwd_cnt   = r_fwd_cnt;
`else
  logic w_unused_fwd_evt;
  assign w_unused_fwd_evt = w_fwd_evt;
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Generalised operand-forwarding network merged with a register scoreboard for the decode/execute boundary of the core.
- Serves N_RD operand read ports from N_STG in-flight pipeline stages, with fixed youngest-first priority.
- Tracks per-register countdown timers for long-latency ops (multi-cycle mul/div, loads) and raises a single stall when an operand or target is not yet available.
- Replaces fixed two-read, three-stage forwarding with a parametrised, stateful hazard block.

Parameters:
DATA_W, 24, operand/result width
REG_W, 4, register index width (2**REG_W registers)
N_RD, 2, operand read ports
N_STG, 3, forwarding stages; index 0 = youngest (EX/MA), N_STG-1 = oldest (MO/WB)
LAT_W, 3, latency field width; max tracked latency 2**LAT_W-1

Ports:
iw_clk  in  1  clock
iw_rst  in  1  reset
iw_rd_en  in  N_RD  read port k needs an operand
iw_rd_addr  in  N_RD*REG_W  register index per port, port k at [k*REG_W +: REG_W]
iw_rf_data  in  N_RD*DATA_W  register-file read data per port
iw_stg_we  in  N_STG  stage s will write a register
iw_stg_tgt  in  N_STG*REG_W  stage s target register
iw_stg_vld  in  N_STG  stage s result is already computed (0 = load/multicycle, not yet available)
iw_stg_res  in  N_STG*DATA_W  stage s result
iw_issue  in  1  decode presents an instruction this cycle
iw_issue_we  in  1  that instruction writes a register
iw_issue_tgt  in  REG_W  its target register
iw_issue_lat  in  LAT_W  scoreboard latency; 0 = ordinary pipelined op, not tracked
iw_flush  in  1  squash the instruction in decode
or_rd_val  out  N_RD*DATA_W  forwarded operand per port
or_stall  out  1  hold decode this cycle
or_busy  out  2**REG_W  registered scoreboard busy mask

Behaviour:
- Clock and reset: one clock iw_clk; iw_rst asynchronous, active-high.
- Reset state: all counters 0; or_busy = 0. or_stall and or_rd_val are combinational; with reset asserted they follow their inputs, with the scoreboard empty.
- Forwarding, combinational, per port k:
  - Scan stages 0..N_STG-1 and take the first s with iw_stg_we[s] && iw_stg_tgt[s]==iw_rd_addr[k].
  - On a hit, or_rd_val[k] = iw_stg_res[s]; on a miss, or_rd_val[k] = iw_rf_data[k].
  - Older stages never override a younger hit.
- Data hazard, port k: iw_rd_en[k] && first hit s has iw_stg_vld[s]==0. Hazard regardless of older valid matches.
- Scoreboard hazard, port k: iw_rd_en[k] && cnt[iw_rd_addr[k]]!=0 && no stage hit with vld=1.
- WAW hazard: iw_issue && iw_issue_we && cnt[iw_issue_tgt]!=0.
- or_stall = iw_issue && !iw_flush && (any port data hazard || any port scoreboard hazard || WAW). With iw_issue=0, or_stall=0.
- Accept = iw_issue && !iw_flush && !or_stall.
- Counter update, every clock edge, per register r:
  - If accept && iw_issue_we && iw_issue_lat!=0 && r==iw_issue_tgt: cnt[r] <= iw_issue_lat.
  - Else if cnt[r]!=0: cnt[r] <= cnt[r]-1.
  - Load wins over decrement. It cannot collide with a nonzero counter, because WAW stalls.
- or_busy[r] = (cnt[r]!=0), taken from registered state; 0-cycle latency from counter.
- Counters reaching 0 clear busy on that edge. The register's producer writes back (stage or RF) the same cycle the counter reaches 0.
- Flush: drops only the decode instruction; already-loaded counters keep running.
- Reset mid-operation clears all counters immediately (async).
- Max latency 2**LAT_W-1; no overflow is possible.

Optional Feature:
- Macro FWD_SCOREBOARD_STATS_EN.
- When defined, adds:
  - Output or_stall_cnt (16 bits): counts cycles with or_stall=1, saturates at 16'hFFFF, cleared by iw_rst.
  - Output or_fwd_cnt (16 bits): counts cycles where any enabled port took a stage hit with vld=1, same saturation and reset.
- When undefined: ports absent, no counters, otherwise identical behaviour.

Test Plan:
- Priority: stage0 and stage2 both target r3 with res 0x000111 and 0x000333, all vld=1; port0 reads r3 -> or_rd_val[0]=0x000111, or_stall=0.
- Load-use: stage0 targets r5 with vld=0, stage1 targets r5 with vld=1; issue reading r5 -> or_stall=1. Next cycle stage0 vld=1, res 0x00ABCD -> or_stall=0, operand 0x00ABCD.
- Scoreboard countdown: accept issue writing r7 with lat=3 -> or_busy[7]=1 for 3 cycles, then 0. A read of r7 stalls in those 3 cycles and passes on cycle 4 with the RF value.
- WAW plus flush: r2 busy (cnt=2); issue writing r2 -> stall. Same with iw_flush=1 -> or_stall=0 and cnt[2] unchanged (decrements normally).
- Async reset: r1 loaded with lat=7; assert iw_rst between edges -> or_busy=0 immediately, a subsequent read of r1 does not stall.
- With FWD_SCOREBOARD_STATS_EN: 5 stall cycles then 2 forwarded cycles -> or_stall_cnt=5, or_fwd_cnt=2.
